// File: rtl/instr_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : instr_fetch                                              |
// | Description : PC / instruction-memory fetch stage with a single-entry  |
// |               valid/ready buffer and control-flow redirect handling.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_src_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    localparam logic [1:0] c_op_none = 2'b00;
    localparam logic [1:0] c_op_bne  = 2'b01;
    localparam logic [1:0] c_op_j    = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic        w_redir;
    logic [31:0] w_src_plus4;
    logic [31:0] w_target;
    logic        w_unused;

    assign w_redir     = (redir_op != c_op_none);
    assign w_src_plus4 = redir_src_pc + 32'd4;
    assign w_unused    = ^redir_reg[1:0];

    always_comb begin
        w_target = {redir_reg[31:2], 2'b00};
        case (redir_op)
            c_op_bne: w_target = w_src_plus4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
            c_op_j:   w_target = {w_src_plus4[31:28], redir_imm, 2'b00};
            default:  w_target = {redir_reg[31:2], 2'b00};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a redirect outranks both ack and ready
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                w_state_next = c_st_fetch;
            end
            c_st_fetch: begin
                if (w_redir) begin
                    w_state_next = imem_ack ? c_st_fetch : c_st_drain;
                end else if (imem_ack) begin
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                if (w_redir || inst_ready) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_drain: begin
                if (imem_ack) begin
                    w_state_next = c_st_fetch;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Outputs decoded from registered state; DRAIN keeps the abandoned address on the bus
    always_comb begin
        imem_req   = (r_state == c_st_fetch) || (r_state == c_st_drain);
        imem_addr  = (r_state == c_st_drain) ? r_drain_addr : r_pc;
        inst_valid = (r_state == c_st_hold);
        inst       = r_inst;
        inst_pc    = r_inst_pc;
    end

    // Datapath: pc, drain address and instruction buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            if (w_redir) begin
                r_pc <= w_target;
                if ((r_state == c_st_fetch) && !imem_ack) begin
                    r_drain_addr <= r_pc;
                end
            end else if ((r_state == c_st_fetch) && imem_ack) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
                r_pc      <= r_pc + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                           |
// | Description : Directed self-checking bench for instr_fetch.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  redir_op;
    logic [31:0] redir_src_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .redir_op     (redir_op),
        .redir_src_pc (redir_src_pc),
        .redir_imm    (redir_imm),
        .redir_reg    (redir_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [1:0] op, input logic [31:0] src,
                            input logic [25:0] imm, input logic [31:0] rs);
        redir_op     = op;
        redir_src_pc = src;
        redir_imm    = imm;
        redir_reg    = rs;
    endtask

    // Serve the current FETCH after lat idle cycles, then leave the bus quiet
    task automatic serve(input logic [31:0] data, input int lat);
        for (int i = 0; i < lat; i++) begin
            tick();
            check_eq("wait_req", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b1;
        redirect(2'b00, 32'd0, 26'd0, 32'd0);

        // Reset state
        tick(); tick();
        check_eq("rst_req",    {31'd0, imem_req},   32'd0);
        check_eq("rst_valid",  {31'd0, inst_valid}, 32'd0);
        check_eq("rst_addr",   imem_addr,           32'h0);
        check_eq("rst_inst",   inst,                32'h0);
        check_eq("rst_instpc", inst_pc,             32'h0);
        rst_n = 1'b1;
        check_eq("idle_req",   {31'd0, imem_req},   32'd0);
        tick();
        check_eq("first_req",  {31'd0, imem_req},   32'd1);
        check_eq("first_addr", imem_addr,           32'h0);

        // Sequential fetch, L=0
        serve(32'hA000_0000, 0);
        check_eq("h0_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("h0_inst",  inst,                32'hA000_0000);
        check_eq("h0_pc",    inst_pc,             32'h0);
        check_eq("h0_req",   {31'd0, imem_req},   32'd0);
        tick();
        check_eq("f1_addr",  imem_addr,           32'h4);
        serve(32'hA000_0001, 0);
        check_eq("h1_inst",  inst,                32'hA000_0001);
        check_eq("h1_pc",    inst_pc,             32'h4);
        tick();
        check_eq("f2_addr",  imem_addr,           32'h8);

        // L=3
        serve(32'hA000_0002, 3);
        check_eq("h2_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("h2_inst",  inst,                32'hA000_0002);
        check_eq("h2_pc",    inst_pc,             32'h8);

        // Backpressure for 5 cycles
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'd0, inst_valid}, 32'd1);
            check_eq("bp_inst",  inst,                32'hA000_0002);
            check_eq("bp_pc",    inst_pc,             32'h8);
            check_eq("bp_req",   {31'd0, imem_req},   32'd0);
        end
        inst_ready = 1'b1;
        tick();
        check_eq("bp_next_addr", imem_addr, 32'hC);
        serve(32'hA000_0003, 0);
        check_eq("h3_pc", inst_pc, 32'hC);
        inst_ready = 1'b0;

        // BNE in HOLD: 0x10 + 4 - 8 = 0x0C
        redirect(2'b01, 32'h10, 26'h000FFFE, 32'd0);
        tick();
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        inst_ready = 1'b1;
        check_eq("bne_addr",  imem_addr,           32'hC);
        check_eq("bne_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("bne_req",   {31'd0, imem_req},   32'd1);

        // Redirect together with ack: response dropped
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        redirect(2'b11, 32'd0, 26'd0, 32'h8);
        tick();
        imem_ack   = 1'b0;
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        check_eq("ackred_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("ackred_addr",  imem_addr,           32'h8);
        check_eq("ackred_inst",  inst,                32'hA000_0003);

        // J during FETCH at 0x8, ack two cycles later
        redirect(2'b10, 32'h4, 26'h40, 32'd0);
        tick();
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        check_eq("j_drain_addr",  imem_addr,           32'h8);
        check_eq("j_drain_req",   {31'd0, imem_req},   32'd1);
        check_eq("j_drain_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("j_drain_addr2", imem_addr,           32'h8);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        tick();
        imem_ack   = 1'b0;
        check_eq("j_target",  imem_addr,           32'h100);
        check_eq("j_valid",   {31'd0, inst_valid}, 32'd0);

        // Two redirects: J then JR during DRAIN; JR wins
        redirect(2'b10, 32'h4, 26'h300, 32'd0);
        tick();
        check_eq("jj_drain_addr", imem_addr, 32'h100);
        redirect(2'b11, 32'd0, 26'd0, 32'h203);
        tick();
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        check_eq("jr_drain_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        tick();
        imem_ack   = 1'b0;
        check_eq("jr_target", imem_addr,           32'h200);
        check_eq("jr_valid",  {31'd0, inst_valid}, 32'd0);
        serve(32'hA000_0004, 1);
        check_eq("h4_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("h4_inst",  inst,                32'hA000_0004);
        check_eq("h4_pc",    inst_pc,             32'h200);

        // PC wrap at top of address space
        redirect(2'b11, 32'd0, 26'd0, 32'hFFFF_FFFF);
        tick();
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        serve(32'hA000_0005, 0);
        check_eq("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_next", imem_addr, 32'h0);

        // Reset pulse mid-DRAIN
        redirect(2'b10, 32'h4, 26'h10, 32'd0);
        tick();
        redirect(2'b00, 32'd0, 26'd0, 32'd0);
        check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req",    {31'd0, imem_req},   32'd0);
        check_eq("mid_rst_addr",   imem_addr,           32'h0);
        check_eq("mid_rst_valid",  {31'd0, inst_valid}, 32'd0);
        check_eq("mid_rst_inst",   inst,                32'h0);
        check_eq("mid_rst_instpc", inst_pc,             32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
